// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default geometry, also used by
// receptor-side models.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        SETUP        = 2'b01,
        TRANSMISSION = 2'b10,
        HOLD         = 2'b11
    } spi_state_e;

    localparam int unsigned DIV_SCK_DEF = 4;
    localparam int unsigned N_BITS_DEF  = 16;

endpackage

// File: rtl/transmisor_spi_gen_sck.sv
// SCK generator: half-period divider that toggles SCK while enabled and flags the
// cycle before each leading/trailing SCK edge with a one-cycle strobe.
module gen_sck
    import spi_pkg::*;
#(
    parameter int unsigned DIV_SCK = DIV_SCK_DEF
) (
    input  logic CLK,
    input  logic reset_tra,
    input  logic en,
    input  logic kick,
    input  logic ckp,
    output logic sck,
    output logic lead_stb,
    output logic trail_stb
);

    localparam int unsigned HALF = DIV_SCK / 2;
    localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          tick;

    always_comb begin
        tick      = en && (div_q == DW'(HALF - 1));
        lead_stb  = tick && (sck_q == ckp);
        trail_stb = tick && (sck_q != ckp);
        div_d     = '0;
        sck_d     = ckp;
        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
            sck_d = tick ? ~sck_q : sck_q;
        end else if (kick) begin
            // kick makes the enabling transition itself a leading edge
            sck_d = ~ckp;
        end
    end

    always_ff @(posedge CLK or negedge reset_tra) begin
        if (!reset_tra) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/transmisor_spi.sv
// SPI master transmitter, MSB-first, runtime CKP/CPH. Optional back-to-back words
// under a single CS low when TRANSMISOR_SPI_CONT_EN is defined.
module transmisor_spi
    import spi_pkg::*;
#(
    parameter int unsigned DIV_SCK = DIV_SCK_DEF,
    parameter int unsigned N_BITS  = N_BITS_DEF
) (
    input  logic              CLK,
    input  logic              reset_tra,
    input  logic              inicio,
    input  logic [N_BITS-1:0] dato_tx,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              MISO,
    output logic              SCK,
    output logic              CS,
    output logic              MOSI,
    output logic [N_BITS-1:0] dato_rx,
    output logic              listo,
    output logic              ocupado
);

    localparam int unsigned HALF = DIV_SCK / 2;
    localparam int unsigned TW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BW   = $clog2(N_BITS) + 1;

    spi_state_e        state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_BITS-1:0] sh_q, sh_d;
    logic [N_BITS-1:0] rx_q, rx_d;
    logic [N_BITS-1:0] drx_q, drx_d;
    logic              ckp_q, ckp_d;
    logic              cph_q, cph_d;
    logic              listo_q, listo_d;

    logic lead_stb, trail_stb;
    logic sck_en, sck_kick, ckp_sel, half_done;

    assign half_done = (tmr_q == TW'(HALF - 1));
    assign sck_en    = (state_q == TRANSMISSION);
    assign ckp_sel   = (state_q == IDLE) ? CKP : ckp_q;

    gen_sck #(
        .DIV_SCK (DIV_SCK)
    ) u_gen_sck (
        .CLK       (CLK),
        .reset_tra (reset_tra),
        .en        (sck_en),
        .kick      (sck_kick),
        .ckp       (ckp_sel),
        .sck       (SCK),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    always_comb begin
        state_d  = state_q;
        tmr_d    = '0;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        drx_d    = drx_q;
        ckp_d    = ckp_q;
        cph_d    = cph_q;
        listo_d  = 1'b0;
        sck_kick = 1'b0;
        case (state_q)
            IDLE: begin
                if (inicio) begin
                    sh_d    = dato_tx;
                    ckp_d   = CKP;
                    cph_d   = CPH;
                    bit_d   = '0;
                    rx_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_done) state_d = TRANSMISSION;
                else           tmr_d   = tmr_q + 1'b1;
            end
            TRANSMISSION: begin
                // CPH=1 keeps the MSB on the first leading edge; it is already on MOSI
                if (lead_stb) begin
                    if (!cph_q)          rx_d = N_BITS'({rx_q, MISO});
                    else if (bit_q != 0) sh_d = sh_q << 1;
                end
                if (trail_stb) begin
                    if (!cph_q) sh_d = sh_q << 1;
                    else        rx_d = N_BITS'({rx_q, MISO});
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(N_BITS - 1)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (half_done) begin
                    drx_d   = rx_q;
                    listo_d = 1'b1;
`ifdef TRANSMISOR_SPI_CONT_EN
                    if (inicio) begin
                        sh_d     = dato_tx;
                        bit_d    = '0;
                        rx_d     = cph_q ? '0 : N_BITS'(MISO);
                        sck_kick = 1'b1;
                        state_d  = TRANSMISSION;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_tra) begin
        if (!reset_tra) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            drx_q   <= '0;
            ckp_q   <= 1'b0;
            cph_q   <= 1'b0;
            listo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            drx_q   <= drx_d;
            ckp_q   <= ckp_d;
            cph_q   <= cph_d;
            listo_q <= listo_d;
        end
    end

    assign CS      = (state_q == IDLE);
    assign ocupado = (state_q != IDLE);
    assign MOSI    = (state_q != IDLE) && sh_q[N_BITS-1];
    assign dato_rx = drx_q;
    assign listo   = listo_q;

endmodule

// File: tb/tb_transmisor_spi.sv
// Scoreboarded bench for transmisor_spi with an SPI slave model; the continuous
// mode scenario runs only when TRANSMISOR_SPI_CONT_EN is defined.
module tb_transmisor_spi;

    localparam int unsigned DIV = 4;
    localparam int unsigned NB  = 16;
    localparam int unsigned LAT = 1 + (NB + 1) * DIV;

    logic          CLK = 1'b0;
    logic          reset_tra = 1'b0;
    logic          inicio = 1'b0;
    logic [NB-1:0] dato_tx = '0;
    logic          CKP = 1'b0;
    logic          CPH = 1'b0;
    logic          MISO;
    logic          SCK, CS, MOSI, listo, ocupado;
    logic [NB-1:0] dato_rx;

    transmisor_spi #(
        .DIV_SCK (DIV),
        .N_BITS  (NB)
    ) dut (
        .CLK       (CLK),
        .reset_tra (reset_tra),
        .inicio    (inicio),
        .dato_tx   (dato_tx),
        .CKP       (CKP),
        .CPH       (CPH),
        .MISO      (MISO),
        .SCK       (SCK),
        .CS        (CS),
        .MOSI      (MOSI),
        .dato_rx   (dato_rx),
        .listo     (listo),
        .ocupado   (ocupado)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int unsigned pass_cnt = 0;
    int unsigned tot_cnt  = 0;
    int unsigned listo_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tot_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // scoreboard of expected completions
    typedef struct {
        logic [NB-1:0] rx;
        int unsigned   at;
    } exp_t;
    exp_t sbq[$];

    logic listo_prev = 1'b0;
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (reset_tra && listo) begin
            listo_seen++;
            if (listo_prev) begin
                tot_cnt++;
                $display("FAIL listo_width: listo high on consecutive cycles at %0d", cyc);
            end
            if (sbq.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_listo: got listo at cycle %0d required none", cyc);
            end else begin
                e = sbq.pop_front();
                check("dato_rx", dato_rx, e.rx);
                check("listo_cycle", cyc, e.at);
            end
        end
        listo_prev <= listo;
    end

    // SPI slave: shifts out miso_word (or echoes MOSI) and captures MOSI
    logic          cur_ckp = 1'b0, cur_cph = 1'b0, echo = 1'b0;
    logic [NB-1:0] miso_word = '0;
    logic [NB-1:0] mosi_cap = '0;
    logic          miso_r = 1'b0;
    logic          sck_prev = 1'b0, cs_prev = 1'b1, sck_start = 1'b0;
    int            lead_cnt = 0, trail_cnt = 0;

    assign MISO = echo ? MOSI : miso_r;

    always @(negedge CLK) begin
        if (cs_prev && !CS) begin
            lead_cnt  <= 0;
            trail_cnt <= 0;
            mosi_cap  <= '0;
            sck_start <= SCK;
            miso_r    <= miso_word[NB-1];
        end else if (!CS && SCK != sck_prev) begin
            if (sck_prev == cur_ckp) begin
                lead_cnt <= lead_cnt + 1;
                if (!cur_cph) mosi_cap <= {mosi_cap[NB-2:0], MOSI};
                else if (lead_cnt < NB) miso_r <= miso_word[NB-1-lead_cnt];
            end else begin
                trail_cnt <= trail_cnt + 1;
                if (cur_cph) mosi_cap <= {mosi_cap[NB-2:0], MOSI};
                else if (trail_cnt < NB - 1) miso_r <= miso_word[NB-2-trail_cnt];
            end
        end
        cs_prev  <= CS;
        sck_prev <= SCK;
    end

    task automatic wait_idle(input string name, input int unsigned bound);
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (!ocupado) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // mode 0: plain start; mode 1: inicio held and re-pulsed mid-transaction
    task automatic run_txn(input logic [NB-1:0] d, input logic ckp, input logic cph,
                           input logic ech, input logic [NB-1:0] mw, input int mode);
        exp_t        e;
        int unsigned k;
        @(negedge CLK);
        cur_ckp = ckp; cur_cph = cph; CKP = ckp; CPH = cph;
        echo = ech; miso_word = mw;
        repeat (2) @(negedge CLK);
        check("idle_sck", SCK, ckp);
        inicio = 1'b1; dato_tx = d; k = cyc;
        e.rx = ech ? d : mw;
        e.at = k + LAT;
        sbq.push_back(e);
        for (int c = 1; c <= 45; c++) begin
            @(negedge CLK);
            if (mode == 1) inicio = (c < 5) || (c == 10) || (c == 40);
            else           inicio = 1'b0;
            dato_tx = NB'($urandom);
            CKP = 1'($urandom);
            CPH = 1'($urandom);
        end
        wait_idle("txn_done", 100);
        repeat (2) @(negedge CLK);
        check("mosi_stream", mosi_cap, d);
        check("lead_edges", lead_cnt, NB);
        check("sck_idle_level", sck_start, ckp);
        check("cs_idle", CS, 1'b1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned seen0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_cs", CS, 1'b1);
        check("rst_sck", SCK, 1'b0);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_dato_rx", dato_rx, '0);
        check("rst_listo", listo, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        CKP = 1'b1;
        reset_tra = 1'b1;
        @(posedge CLK); #1;
        check("sck_after_reset", SCK, 1'b1);
        CKP = 1'b0;

        run_txn(16'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0106, 0);
        for (int m = 0; m < 4; m++)
            run_txn(16'h8001, 1'(m >> 1), 1'(m), 1'b1, '0, 0);
        run_txn(16'h5A5A, 1'b0, 1'b1, 1'b0, 16'hFFFF, 0);
        run_txn(16'hC3C3, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
        for (int r = 0; r < 8; r++)
            run_txn(NB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), NB'($urandom), 0);

        seen0 = listo_seen;
        run_txn(16'h3C5A, 1'b0, 1'b0, 1'b1, '0, 1);
        repeat (LAT + 10) @(negedge CLK);
        check("single_listo", listo_seen - seen0, 1);

        // reset cut mid-transaction: no completion is queued
        @(negedge CLK);
        cur_ckp = 1'b0; cur_cph = 1'b0; CKP = 1'b0; CPH = 1'b0; echo = 1'b1;
        inicio = 1'b1; dato_tx = 16'hBEEF; k = cyc;
        @(negedge CLK);
        inicio = 1'b0;
        while (cyc < k + 30) @(negedge CLK);
        seen0 = listo_seen;
        reset_tra = 1'b0;
        #1;
        check("abort_cs", CS, 1'b1);
        check("abort_sck", SCK, 1'b0);
        check("abort_ocupado", ocupado, 1'b0);
        check("abort_dato_rx", dato_rx, '0);
        @(negedge CLK);
        reset_tra = 1'b1;
        repeat (LAT + 10) @(negedge CLK);
        check("abort_no_listo", listo_seen - seen0, 0);
        check("abort_dato_rx_hold", dato_rx, '0);

`ifdef TRANSMISOR_SPI_CONT_EN
        begin
            exp_t        e;
            int unsigned cs_high;
            @(negedge CLK);
            cur_ckp = 1'b0; cur_cph = 1'b0; CKP = 1'b0; CPH = 1'b0;
            echo = 1'b0; miso_word = 16'hFFFF;
            repeat (2) @(negedge CLK);
            inicio = 1'b1; dato_tx = 16'h9ABC; k = cyc;
            e.rx = 16'hFFFF; e.at = k + LAT;               sbq.push_back(e);
            e.rx = 16'hFFFF; e.at = k + 1 + (2 * NB + 1) * DIV; sbq.push_back(e);
            @(negedge CLK);
            inicio = 1'b0;
            cs_high = 0;
            while (cyc < k + 1 + (2 * NB + 1) * DIV) begin
                inicio = (cyc >= k + LAT - DIV / 2) && (cyc < k + LAT);
                if (inicio) dato_tx = 16'h1234;
                if (CS) cs_high++;
                @(negedge CLK);
            end
            inicio = 1'b0;
            check("cont_cs_low", cs_high, 0);
            wait_idle("cont_done", 20);
            repeat (2) @(negedge CLK);
            check("cont_lead_edges", lead_cnt, 2 * NB);
            check("cont_mosi_word2", mosi_cap, 16'h1234);
        end
`endif

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/transmisor_spi.md
TRANSMISOR_SPI -- requirements
Module: transmisor_spi

Interface
REQ-001 SHALL have parameter DIV_SCK, default 4, meaning CLK cycles per SCK period; even, >=2.
REQ-002 SHALL have parameter N_BITS, default 16, meaning bits per transaction and the width of dato_tx/dato_rx.
REQ-003 SHALL have port CLK, input, 1, the single system clock; all flops on posedge CLK.
REQ-004 SHALL have port reset_tra, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port inicio, input, 1, start request, sampled only in IDLE.
REQ-006 SHALL have port dato_tx, input, N_BITS, word to send MSB-first, captured at start.
REQ-007 SHALL have ports CKP and CPH, inputs, 1 each: SPI clock polarity and phase, latched at start.
REQ-008 SHALL have port MISO, input, 1, serial data from the receiver.
REQ-009 SHALL have ports SCK, CS and MOSI, outputs, 1 each: serial clock, active-low chip select, and serial data to the receiver.
REQ-010 SHALL have port dato_rx, output, N_BITS, last word received.
REQ-011 SHALL have ports listo and ocupado, outputs, 1 each: listo is a one-cycle done pulse; ocupado is high while a transaction is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, TRANSMISSION and HOLD.
REQ-013 SHALL, in IDLE, hold CS=1, SCK=CKP, MOSI=0 and ocupado=0.
REQ-014 SHALL, when inicio=1 in IDLE at cycle k, load the shift register with dato_tx, latch CKP/CPH, and enter SETUP with CS=0 and ocupado=1 from cycle k+1.
REQ-015 SHALL stay in SETUP for DIV_SCK/2 cycles with SCK idle and MOSI=dato_tx[MSB].
REQ-016 SHALL, in TRANSMISSION, toggle SCK every DIV_SCK/2 cycles for exactly N_BITS periods; the first edge is the leading edge.
REQ-017 SHALL, when CPH=0, sample MISO on the leading edge and shift/drive the next MOSI bit on the trailing edge.
REQ-018 SHALL, when CPH=1, drive MOSI on the leading edge and sample MISO on the trailing edge.
REQ-019 SHALL, after the last SCK edge, keep SCK at idle and hold CS=0 in HOLD for DIV_SCK/2 cycles.
REQ-020 SHALL, on the cycle after HOLD, return to IDLE with CS=1, update dato_rx, assert listo for exactly one cycle and deassert ocupado.
REQ-021 SHALL give a total latency of inicio at cycle k -> listo at k+1+(N_BITS+1)*DIV_SCK, i.e. k+69 with defaults.
REQ-022 SHALL ignore inicio while ocupado=1, and shall ignore changes to dato_tx, CKP and CPH mid-transaction.
REQ-023 SHALL keep dato_rx stable between listo pulses.
REQ-024 SHALL use a bit counter of width clog2(N_BITS)+1 that never wraps within a transaction.

Reset
REQ-025 SHALL, when reset_tra=0 at any time including mid-transaction, immediately force state=IDLE, CS=1, SCK=0, MOSI=0, dato_rx=0, listo=0, ocupado=0 and counters to 0.
REQ-026 SHALL drive SCK=CKP from the first cycle after reset release.
REQ-027 SHALL abort any transaction cut by reset with no listo and no dato_rx update.

Configuration
REQ-028 SHALL, when TRANSMISOR_SPI_CONT_EN is defined and inicio=1 in HOLD, skip CS deassertion, pulse listo, update dato_rx, reload dato_tx and go directly to TRANSMISSION (back-to-back words under one CS low).
REQ-029 SHALL, without TRANSMISOR_SPI_CONT_EN, always pass through IDLE with CS=1 for at least one cycle between transactions.

Structure
REQ-030 SHALL place the state encoding (2-bit: IDLE=2'b00, SETUP=2'b01, TRANSMISSION=2'b10, HOLD=2'b11) and defaults for DIV_SCK and N_BITS in shared package spi_pkg, also used by receptor-side models.
REQ-031 SHALL implement SCK generation and leading/trailing edge strobes in sub-module gen_sck, enabled by the FSM and outputting lead_stb and trail_stb one CLK cycle wide.

Verification
REQ-032 SHALL cover: CKP=0, CPH=0, dato_tx=16'hA5C3, MISO model returns 16'h0106 -> MOSI stream A5C3 MSB-first, dato_rx=16'h0106, listo at k+69.
REQ-033 SHALL cover: all four CKP/CPH modes, dato_tx=16'h8001, MISO echo of MOSI -> dato_rx=16'h8001, SCK idle level = CKP, exactly 16 leading edges.
REQ-034 SHALL cover: inicio held high and repulsed at k+10 and k+40 -> single transaction, one listo pulse.
REQ-035 SHALL cover: reset_tra low at k+30 -> CS=1 and SCK=0 within the same cycle, no listo, dato_rx=0.
REQ-036 SHALL cover: with TRANSMISOR_SPI_CONT_EN, inicio high in HOLD with second word 16'h1234 -> CS stays low across 32 bits and two listo pulses, the second at k+1+33*DIV_SCK.
REQ-037 SHALL cover: MISO=1 constant -> dato_rx=16'hFFFF, and MISO=0 constant -> dato_rx=16'h0000.
